// File: rtl/uart_boot_ctrl.sv
// Boot sequencer: loads a UART program image into RAM, answers ACK/NAK, then hands RX/TX/RAM to the CORE.
// Optional inter-byte timeout is built when UART_BOOT_TIMEOUT_EN is defined.
`default_nettype none

module uart_boot_ctrl #(
    parameter int         ADDR_W    = 13,
    parameter logic [7:0] SYNC_BYTE = 8'hFF,
    parameter logic [7:0] ACK_BYTE  = 8'h06,
    parameter logic [7:0] NAK_BYTE  = 8'h15
`ifdef UART_BOOT_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 50000000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_empty,
    input  logic [7:0]        rx_q,
    output logic              rx_rdreq,
    input  logic              tx_full,
    output logic [31:0]       tx_data,
    output logic              tx_wrreq,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic              ram_we,
    input  logic [ADDR_W-1:0] core_ram_addr,
    input  logic [31:0]       core_ram_data,
    input  logic              core_ram_we,
    input  logic              core_rx_rdreq,
    input  logic              core_tx_wrreq,
    input  logic [31:0]       core_tx_data,
    output logic              core_run,
    output logic              boot_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CNT_LO = 3'd1;
    localparam logic [2:0] S_CNT_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;
    localparam logic [2:0] S_RUN    = 3'd6;

    localparam logic [16:0]     MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] WORD_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic              rdreq_r;
    logic              cap_r;
    logic [7:0]        csum_r;
    logic [15:0]       cnt_r;
    logic [1:0]        byte_idx_r;
    logic [ADDR_W:0]   word_idx_r;
    logic [23:0]       word_r;
    logic              ack_r;
    logic              tx_wrreq_r;
    logic [31:0]       tx_data_r;
    logic              ram_we_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [31:0]       ram_data_r;
    logic              core_run_r;
    logic              boot_err_r;

    logic [16:0]       cnt_full_s;
    logic              words_done_s;
    logic              recv_nxt_s;
    logic              timeout_s;

    // The count high byte is still on rx_q when CNT_HI decides where to go.
    assign cnt_full_s   = {1'b0, rx_q, cnt_r[7:0]};
    assign words_done_s = (17'(word_idx_r) == {1'b0, cnt_r});
    assign recv_nxt_s   = (state_nxt_s != S_RESP) && (state_nxt_s != S_RUN);

`ifdef UART_BOOT_TIMEOUT_EN
    localparam logic [25:0] TMO_LAST = 26'(TIMEOUT_CYCLES - 1);

    logic [25:0] tmo_r;
    logic        tmo_active_s;

    assign tmo_active_s = (state_r == S_CNT_LO) || (state_r == S_CNT_HI) ||
                          (state_r == S_DATA)   || (state_r == S_CSUM);
    assign timeout_s    = tmo_active_s && (tmo_r == TMO_LAST);

    // Inter-byte idle counter, restarted by every captured byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_r <= 26'd0;
        end else if (!tmo_active_s || cap_r || timeout_s) begin
            tmo_r <= 26'd0;
        end else begin
            tmo_r <= tmo_r + 26'd1;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state decode; DATA leaves only after the last word's write cycle.
    always_comb begin
        state_nxt_s = state_r;
        if (timeout_s) begin
            state_nxt_s = S_RESP;
        end else begin
            case (state_r)
                S_IDLE:   state_nxt_s = (cap_r && (rx_q == SYNC_BYTE)) ? S_CNT_LO : S_IDLE;
                S_CNT_LO: state_nxt_s = cap_r ? S_CNT_HI : S_CNT_LO;
                S_CNT_HI: begin
                    if (!cap_r) begin
                        state_nxt_s = S_CNT_HI;
                    end else if (cnt_full_s > MAX_WORDS) begin
                        state_nxt_s = S_RESP;
                    end else if (cnt_full_s == 17'd0) begin
                        state_nxt_s = S_CSUM;
                    end else begin
                        state_nxt_s = S_DATA;
                    end
                end
                S_DATA:   state_nxt_s = (ram_we_r && words_done_s) ? S_CSUM : S_DATA;
                S_CSUM:   state_nxt_s = cap_r ? S_RESP : S_CSUM;
                S_RESP: begin
                    if (tx_wrreq_r) begin
                        state_nxt_s = ack_r ? S_RUN : S_IDLE;
                    end else begin
                        state_nxt_s = S_RESP;
                    end
                end
                S_RUN:    state_nxt_s = S_RUN;
                default:  state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Byte fetch, frame assembly, RAM write and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            rdreq_r    <= 1'b0;
            cap_r      <= 1'b0;
            csum_r     <= 8'd0;
            cnt_r      <= 16'd0;
            byte_idx_r <= 2'd0;
            word_idx_r <= {(ADDR_W + 1){1'b0}};
            word_r     <= 24'd0;
            ack_r      <= 1'b0;
            tx_wrreq_r <= 1'b0;
            tx_data_r  <= 32'd0;
            ram_we_r   <= 1'b0;
            ram_addr_r <= {ADDR_W{1'b0}};
            ram_data_r <= 32'd0;
            core_run_r <= 1'b0;
            boot_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            // Looking at the next state keeps a read from being issued as the frame ends.
            rdreq_r    <= recv_nxt_s && !rx_empty && !rdreq_r;
            cap_r      <= rdreq_r;
            ram_we_r   <= 1'b0;
            tx_wrreq_r <= 1'b0;
            core_run_r <= (state_nxt_s == S_RUN);
            if (timeout_s) begin
                ack_r <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (cap_r) begin
                            csum_r <= 8'd0;
                        end
                    end
                    S_CNT_LO: begin
                        if (cap_r) begin
                            cnt_r[7:0] <= rx_q;
                            csum_r     <= csum_r ^ rx_q;
                        end
                    end
                    S_CNT_HI: begin
                        if (cap_r) begin
                            cnt_r[15:8] <= rx_q;
                            csum_r      <= csum_r ^ rx_q;
                            word_idx_r  <= {(ADDR_W + 1){1'b0}};
                            byte_idx_r  <= 2'd0;
                            ack_r       <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        if (cap_r) begin
                            csum_r     <= csum_r ^ rx_q;
                            byte_idx_r <= byte_idx_r + 2'd1;
                            case (byte_idx_r)
                                2'd0: word_r[7:0]   <= rx_q;
                                2'd1: word_r[15:8]  <= rx_q;
                                2'd2: word_r[23:16] <= rx_q;
                                default: begin
                                    ram_we_r   <= 1'b1;
                                    ram_addr_r <= word_idx_r[ADDR_W-1:0];
                                    ram_data_r <= {rx_q, word_r};
                                    word_idx_r <= word_idx_r + WORD_ONE;
                                end
                            endcase
                        end
                    end
                    S_CSUM: begin
                        if (cap_r) begin
                            ack_r <= (rx_q == csum_r);
                        end
                    end
                    S_RESP: begin
                        if (!tx_wrreq_r && !tx_full) begin
                            tx_wrreq_r <= 1'b1;
                            tx_data_r  <= {24'd0, (ack_r ? ACK_BYTE : NAK_BYTE)};
                        end else if (tx_wrreq_r && !ack_r) begin
                            boot_err_r <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rx_rdreq = core_run_r ? core_rx_rdreq : rdreq_r;
    assign tx_wrreq = core_run_r ? core_tx_wrreq : tx_wrreq_r;
    assign tx_data  = core_run_r ? core_tx_data  : tx_data_r;
    assign ram_we   = core_run_r ? core_ram_we   : ram_we_r;
    assign ram_addr = core_run_r ? core_ram_addr : ram_addr_r;
    assign ram_data = core_run_r ? core_ram_data : ram_data_r;
    assign core_run = core_run_r;
    assign boot_err = boot_err_r;

endmodule

`default_nettype wire

// File: tb/tb_uart_boot_ctrl.sv
// Scoreboard bench for uart_boot_ctrl: frames are built from the protocol rules, expected
// RAM writes and TX words are queued, and a monitor pops and compares on every DUT write.
module tb_uart_boot_ctrl;

    localparam int ADDR_W = 13;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } ram_exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_empty = 1'b1;
    logic [7:0]        rx_q = 8'h00;
    logic              rx_rdreq;
    logic              tx_full;
    logic [31:0]       tx_data;
    logic              tx_wrreq;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_data;
    logic              ram_we;
    logic [ADDR_W-1:0] core_ram_addr;
    logic [31:0]       core_ram_data;
    logic              core_ram_we;
    logic              core_rx_rdreq;
    logic              core_tx_wrreq;
    logic [31:0]       core_tx_data;
    logic              core_run;
    logic              boot_err;

    logic [7:0]  rx_fifo[$];
    logic [7:0]  noise[$];
    logic [31:0] frame_words[$];
    logic [31:0] exp_tx[$];
    ram_exp_t    exp_ram[$];

    int checks = 0;
    int failures = 0;
    int tx_pulses = 0;
    int rd_viol = 0;
    bit core_noise = 1'b1;
    bit exp_err = 1'b0;

    uart_boot_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty), .rx_q(rx_q), .rx_rdreq(rx_rdreq),
        .tx_full(tx_full), .tx_data(tx_data), .tx_wrreq(tx_wrreq),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .core_ram_addr(core_ram_addr), .core_ram_data(core_ram_data), .core_ram_we(core_ram_we),
        .core_rx_rdreq(core_rx_rdreq), .core_tx_wrreq(core_tx_wrreq), .core_tx_data(core_tx_data),
        .core_run(core_run), .boot_err(boot_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor and RX FIFO model: check writes first, then update the FIFO outputs.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!core_run && rx_rdreq && rx_empty) rd_viol++;
            if (ram_we) begin
                chk("ram_we_expected", 64'(exp_ram.size() != 0), 64'd1);
                if (exp_ram.size() != 0) begin
                    ram_exp_t e;
                    e = exp_ram.pop_front();
                    chk("ram_addr", 64'(ram_addr), 64'(e.addr));
                    chk("ram_data", 64'(ram_data), 64'(e.data));
                end
            end
            if (tx_wrreq) begin
                tx_pulses++;
                chk("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
                if (exp_tx.size() != 0) begin
                    logic [31:0] t;
                    t = exp_tx.pop_front();
                    chk("tx_data", 64'(tx_data), 64'(t));
                end
            end
            if (rx_rdreq && rx_fifo.size() != 0) rx_q = rx_fifo.pop_front();
        end
        rx_empty = (rx_fifo.size() == 0);
    end

    task automatic quiet_core();
        core_ram_we = 1'b0; core_ram_addr = '0; core_ram_data = 32'd0;
        core_rx_rdreq = 1'b0; core_tx_wrreq = 1'b0; core_tx_data = 32'd0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (core_noise) begin
                core_ram_we   = 1'($urandom_range(0, 1));
                core_ram_addr = ADDR_W'($urandom);
                core_ram_data = $urandom;
                core_rx_rdreq = 1'($urandom_range(0, 1));
                core_tx_wrreq = 1'($urandom_range(0, 1));
                core_tx_data  = $urandom;
            end
        end
    endtask

    task automatic put(input logic [7:0] b);
        rx_fifo.push_back(b);
        if ($urandom_range(0, 3) == 0) step(int'($urandom_range(1, 4)));
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_tx.size() + exp_ram.size()) != 0 && k < 3000) begin
            step(1);
            k++;
        end
        chk(name, 64'(k < 3000), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_rx_rdreq", 64'(rx_rdreq), 64'd0);
        chk("rst_tx_wrreq", 64'(tx_wrreq), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_data", 64'(ram_data), 64'd0);
        chk("rst_core_run", 64'(core_run), 64'd0);
        chk("rst_boot_err", 64'(boot_err), 64'd0);
        rx_fifo.delete(); exp_ram.delete(); exp_tx.delete();
        exp_err = 1'b0;
        core_noise = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic fill(input int n, input int m);
        frame_words.delete();
        noise.delete();
        for (int i = 0; i < n; i++) frame_words.push_back($urandom);
        for (int i = 0; i < m; i++) noise.push_back(8'($urandom_range(0, 254)));
    endtask

    // Builds one frame from the protocol rules and queues the expected RAM writes and reply.
    task automatic send_frame(input logic [15:0] n, input bit corrupt, input bit hold_full);
        logic [7:0] cs;
        bit ok_len;
        bit ack;
        int base;
        int k;
        ram_exp_t e;
        ok_len = (int'(n) <= (1 << ADDR_W));
        ack = ok_len && !corrupt;
        if (ack) begin
            core_noise = 1'b0;
            quiet_core();
        end
        if (hold_full) tx_full = 1'b1;
        foreach (noise[i]) put(noise[i]);
        noise.delete();
        put(8'hFF);
        put(n[7:0]);
        put(n[15:8]);
        cs = n[7:0] ^ n[15:8];
        if (ok_len) begin
            for (int i = 0; i < int'(n); i++) begin
                e.addr = ADDR_W'(i);
                e.data = frame_words[i];
                exp_ram.push_back(e);
                for (int j = 0; j < 4; j++) begin
                    cs = cs ^ e.data[8*j +: 8];
                    put(e.data[8*j +: 8]);
                end
            end
            if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
            put(cs);
        end
        frame_words.delete();
        exp_tx.push_back({24'd0, (ack ? 8'h06 : 8'h15)});
        if (hold_full) begin
            k = 0;
            while (rx_fifo.size() != 0 && k < 2000) begin
                step(1);
                k++;
            end
            step(4);
            base = tx_pulses;
            step(10);
            chk("tx_held_while_full", 64'(tx_pulses), 64'(base));
            tx_full = 1'b0;
            wait_drain("resp_drain");
            step(3);
            chk("tx_single_pulse", 64'(tx_pulses), 64'(base + 1));
        end else begin
            wait_drain("frame_drain");
            step(3);
        end
        if (!ack) exp_err = 1'b1;
        chk("core_run", 64'(core_run), 64'(ack));
        chk("boot_err", 64'(boot_err), 64'(exp_err));
    endtask

    task automatic pass_through();
        ram_exp_t e;
        logic [31:0] d;
        d = $urandom;
        core_ram_we = 1'b1; core_ram_addr = ADDR_W'(5); core_ram_data = d;
        core_tx_wrreq = 1'b1; core_tx_data = ~d; core_rx_rdreq = 1'b1;
        e.addr = ADDR_W'(5);
        e.data = d;
        exp_ram.push_back(e);
        exp_tx.push_back(~d);
        #1;
        chk("pt_ram_we", 64'(ram_we), 64'd1);
        chk("pt_ram_addr", 64'(ram_addr), 64'd5);
        chk("pt_tx_wrreq", 64'(tx_wrreq), 64'd1);
        chk("pt_rx_rdreq", 64'(rx_rdreq), 64'd1);
        step(1);
        quiet_core();
        step(2);
        chk("pt_queues_empty", 64'(exp_ram.size() + exp_tx.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        tx_full = 1'b0;
        quiet_core();
        step(2);
        do_reset();

        // Noise bytes then a one-word image, checksum 0x01.
        noise = '{8'h12, 8'h34};
        frame_words = '{32'hAABBCCDD};
        send_frame(16'd1, 1'b0, 1'b0);

        // Two-word image with a wrong checksum, then a good frame.
        do_reset();
        fill(2, 0);
        send_frame(16'd2, 1'b1, 1'b0);
        fill(1, 1);
        send_frame(16'd1, 1'b0, 1'b0);

        // Oversize count, then an empty image held behind a full TX FIFO, then core access.
        do_reset();
        fill(0, 0);
        send_frame(16'h2101, 1'b0, 1'b0);
        send_frame(16'd0, 1'b0, 1'b1);
        pass_through();

        // Reset in the middle of the data phase.
        do_reset();
        begin
            ram_exp_t e;
            e.addr = '0;
            e.data = $urandom;
            exp_ram.push_back(e);
            put(8'hFF); put(8'h02); put(8'h00);
            for (int j = 0; j < 4; j++) put(e.data[8*j +: 8]);
            put(8'h5A);
            wait_drain("mid_data_drain");
            step(2);
        end
        do_reset();

        for (int s = 0; s < 5; s++) begin
            int nb;
            int n;
            do_reset();
            nb = int'($urandom_range(0, 2));
            for (int b = 0; b < nb; b++) begin
                n = int'($urandom_range(0, 5));
                fill(n, int'($urandom_range(0, 2)));
                send_frame(16'(n), 1'b1, 1'b0);
            end
            n = int'($urandom_range(0, 6));
            fill(n, int'($urandom_range(0, 2)));
            send_frame(16'(n), 1'b0, (s == 2));
            if (s % 2 == 1) pass_through();
        end

        chk("rdreq_while_empty", 64'(rd_viol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_boot_ctrl.md
Name: uart_boot_ctrl

Overview:
- Boot sequencer and resource arbiter between the UART FIFOs, the program RAM and the CORE.
- After reset it owns the RX FIFO read port, the TX FIFO write port and the RAM write port. It loads a program image received over UART into RAM, then answers ACK or NAK.
- On ACK it hands all three resources to the CORE and asserts core_run. This replaces the ad-hoc 0xFF start flag.

Parameters:
- ADDR_W, 13, RAM word-address width; max image size is 2**ADDR_W words.
- SYNC_BYTE, 8'hFF, byte that starts a boot frame.
- ACK_BYTE, 8'h06, response sent on good checksum.
- NAK_BYTE, 8'h15, response sent on bad checksum, oversize count or timeout.
- TIMEOUT_CYCLES, 50000000, inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_empty  in  1  RX FIFO empty
- rx_q  in  8  RX FIFO read data, valid the cycle after rx_rdreq
- rx_rdreq  out  1  RX FIFO read request
- tx_full  in  1  TX FIFO full
- tx_data  out  32  TX FIFO write data; bits [7:0] are the byte
- tx_wrreq  out  1  TX FIFO write request
- ram_addr  out  ADDR_W  RAM address
- ram_data  out  32  RAM write data
- ram_we  out  1  RAM write enable
- core_ram_addr  in  ADDR_W  CORE RAM address
- core_ram_data  in  32  CORE RAM write data
- core_ram_we  in  1  CORE RAM write enable
- core_rx_rdreq  in  1  CORE RX FIFO read request
- core_tx_wrreq  in  1  CORE TX FIFO write request
- core_tx_data  in  32  CORE TX FIFO write data
- core_run  out  1  CORE enable; high = CORE owns the resources
- boot_err  out  1  sticky flag, set by any NAK, cleared only by reset

Behaviour:
- Reset (async, rst_n low): state IDLE. All registered outputs and internal registers go to 0: rx_rdreq, tx_wrreq, tx_data, ram_we, ram_addr, ram_data, core_run, boot_err, checksum, byte/word counters. Reset mid-load abandons the load; RAM contents are left as-is.
- Byte fetch, in every receiving state:
  - When !rx_empty and no fetch is pending, pulse rx_rdreq for 1 cycle and set pending.
  - Next cycle, capture rx_q and clear pending.
  - Maximum rate is one byte per 2 cycles. rx_rdreq is never asserted while rx_empty=1.
- States:
  - IDLE: fetch bytes. SYNC_BYTE -> CNT_LO. Any other byte is discarded and the state stays IDLE.
  - CNT_LO / CNT_HI: receive the 16-bit word count N, low byte first; both bytes are XORed into the checksum (checksum cleared on entry to CNT_LO).
  - After CNT_HI: if N > 2**ADDR_W -> RESP with NAK; if N == 0 -> CSUM; otherwise -> DATA with word index 0.
  - DATA: assemble 4 bytes little-endian, each XORed into the checksum. The cycle after the 4th byte is captured, ram_we=1 for exactly 1 cycle with ram_addr = word index and ram_data = the assembled word. The index then increments. After word N-1 is written -> CSUM.
  - CSUM: fetch 1 byte. If it equals the running XOR -> RESP with ACK, else -> RESP with NAK.
  - RESP: hold until tx_full=0, then tx_wrreq=1 for 1 cycle with tx_data = {24'b0, byte}. After ACK -> RUN. After NAK -> IDLE and set boot_err.
  - RUN: terminal until reset. core_run=1.
- Arbitration:
  - In RUN: rx_rdreq = core_rx_rdreq, tx_wrreq = core_tx_wrreq, tx_data = core_tx_data, and ram_addr/ram_data/ram_we = the core_ram_* inputs. This is a combinational pass-through with 0 latency.
  - In all other states, core_* inputs are ignored.
- Word index width is ADDR_W+1, so N = 2**ADDR_W is legal and terminates without address wrap.
- No RAM write occurs in RESP, CSUM or IDLE.

Optional Feature:
- Macro: UART_BOOT_TIMEOUT_EN
- Defined:
  - A 26-bit idle counter runs in CNT_LO, CNT_HI, DATA and CSUM, and resets on every captured byte.
  - Reaching TIMEOUT_CYCLES forces RESP with NAK.
  - IDLE and RUN never time out.
- Undefined: no counter is built; the FSM waits indefinitely for bytes.

Test Plan:
- Reset with RX bytes 12 34 FF 01 00 DD CC BB AA, then checksum byte 0x01^0x00^0xDD^0xCC^0xBB^0xAA = 0x01 -> 0x12 and 0x34 discarded; RAM[0]=32'hAABBCCDD written by one ram_we pulse; TX gets 0x06; core_run=1; boot_err=0.
- Frame FF 02 00 with 8 data bytes and a wrong checksum -> RAM[0] and RAM[1] written; TX gets 0x15; state IDLE; boot_err=1; core_run=0. A following good frame then reaches RUN.
- Frame FF 01 21 (N=0x2101 > 8192) -> no ram_we; immediate NAK 0x15.
- Frame FF 00 00 00 -> no RAM write; ACK; RUN. Then drive core_ram_we=1, core_ram_addr=5, core_tx_wrreq=1 -> ram_we=1, ram_addr=5 and tx_wrreq=1 in the same cycle.
- In RESP with tx_full=1 for 10 cycles -> tx_wrreq stays 0, then pulses exactly once when tx_full drops. rx_rdreq stays 0 whenever rx_empty=1.
- With UART_BOOT_TIMEOUT_EN and TIMEOUT_CYCLES=100, stall after FF 01 -> NAK within 101 cycles; rst_n low mid-DATA -> all outputs 0 immediately, state IDLE.
